mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the 64-bit RISC-V pipeline.
- Consumes the EX/MEM register outputs and performs loads/stores through a valid/ready data-cache port.
- Produces registered MEM/WB results.
- Drives `hit`, the global pipeline-advance enable used by the pipeline registers; `hit` stays low while a memory access is outstanding.

Parameters:
- XLEN, 64, data/address width
- LOAD_OP, 7'b0000011, load opcode
- STORE_OP, 7'b0100011, store opcode

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ALUresult  in  64  effective address, or result of a non-memory op
- valB  in  64  store data
- rd  in  5  destination register
- opcode  in  7  instruction opcode
- funct3  in  3  access size/sign (000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU)
- noop  in  1  bubble marker
- pc  in  64  instruction PC
- hit  out  1  pipeline advance enable (combinational)
- req_valid  out  1  cache request valid (combinational)
- req_ready  in  1  cache accepts request
- req_we  out  1  1 = store
- req_addr  out  64  doubleword-aligned address, {ALUresult[63:3],3'b0}
- req_wdata  out  64  valB shifted left by 8*ALUresult[2:0]
- req_strb  out  8  byte enables, aligned to ALUresult[2:0]
- resp_valid  in  1  load data valid / store acknowledged
- resp_rdata  in  64  aligned doubleword
- wb_data  out  64  registered writeback value
- wb_rd  out  5  registered destination register
- wb_we  out  1  registered register-write enable
- wb_noop  out  1  registered bubble flag
- wb_pc  out  64  registered PC
- wb_misaligned  out  1  registered misaligned-access exception flag

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - wb_data, wb_rd, wb_we, wb_pc, wb_misaligned = 0; wb_noop = 1.
  - req_valid = 0 in the following cycle.
  - Reset mid-access abandons the access. The data cache shares rst_n, so no stale response follows.
- Definitions:
  - mem_op = !noop && (opcode==LOAD_OP || opcode==STORE_OP).
  - Size = 1, 2, 4 or 8 bytes from funct3[1:0].
  - mis = mem_op && (ALUresult mod size != 0).
- FSM states: IDLE, REQ, WAIT.
  - IDLE, mem_op && !mis: req_valid=1, hit=0. If req_ready → WAIT, else → REQ.
  - IDLE, otherwise: hit=1, no request.
  - REQ: req_valid=1, hit=0, all request fields held stable; req_ready → WAIT.
  - WAIT: req_valid=0. On resp_valid: hit=1 → IDLE. Otherwise hit=0.
- resp_valid is ignored outside WAIT. The cache never responds in the same cycle it accepts a request; minimum load/store latency is 2 cycles.
- WB register updates only on posedge with hit=1. Values written:
  - wb_rd=rd, wb_pc=pc, wb_noop=noop, wb_misaligned=mis.
  - Load: wb_data = (resp_rdata >> 8*ALUresult[2:0]) truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1). wb_we = (rd!=0).
  - Store: wb_data = ALUresult; wb_we = 0.
  - Non-memory op: wb_data = ALUresult; wb_we = !noop && (rd!=0) && opcode not in {STORE_OP, 7'b1100011 branch}.
  - Misaligned access: wb_we = 0, wb_data = ALUresult, no cache request, completes in 1 cycle.
  - noop: wb_we = 0.
- WB register holds its value while hit=0. Consecutive memory ops each incur the full handshake; there is no overlap.
- req_strb: size-many ones shifted left by ALUresult[2:0]. Loads also drive req_strb; req_wdata is don't-care on loads.

Test Plan:
- ADD result 0x1234, rd=5, noop=0 → hit=1 same cycle; after the edge wb_data=0x1234, wb_we=1, wb_rd=5.
- LB addr 0x1003, resp_rdata=0x0000_0000_8000_0000 after 3-cycle wait → req_addr=0x1000, req_strb=8'h08; hit=0 until resp; wb_data=0xFFFF_FFFF_FFFF_FF80; LBU with the same data → 0x80.
- SW addr 0x2004, valB=0xDEADBEEF, req_ready low for 2 cycles → req_valid held with fields stable; req_strb=8'hF0; req_wdata=0xDEADBEEF_0000_0000; wb_we=0 after ack.
- LD addr 0x3004 → no request, hit=1, wb_misaligned=1, wb_we=0.
- rst_n low while in WAIT → next cycle state=IDLE, req_valid=0, wb_noop=1, wb_we=0; a following ADD completes normally.
- noop=1 with opcode=LOAD_OP → no request, hit=1, wb_we=0, wb_noop=1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the 64-bit RISC-V pipeline: issues loads/stores over a
// valid/ready cache port, stalls the pipeline via hit, and registers MEM/WB results.
module mem_stage #(
    parameter int         XLEN     = 64,
    parameter logic [6:0] LOAD_OP  = 7'b0000011,
    parameter logic [6:0] STORE_OP = 7'b0100011
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ALUresult,
    input  logic [XLEN-1:0] valB,
    input  logic [4:0]      rd,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            noop,
    input  logic [XLEN-1:0] pc,
    output logic            hit,
    output logic            req_valid,
    input  logic            req_ready,
    output logic            req_we,
    output logic [XLEN-1:0] req_addr,
    output logic [XLEN-1:0] req_wdata,
    output logic [7:0]      req_strb,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_rdata,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic            wb_noop,
    output logic [XLEN-1:0] wb_pc,
    output logic            wb_misaligned
);

    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic              is_load_s;
    logic              is_store_s;
    logic              mem_op_s;
    logic              mis_s;
    logic              wb_we_s;
    logic [XLEN-1:0]   wb_data_s;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            2'b11:   align_mask = 3'b111;
            default: align_mask = 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] strb_base(input logic [1:0] sz);
        case (sz)
            2'b00:   strb_base = 8'h01;
            2'b01:   strb_base = 8'h03;
            2'b10:   strb_base = 8'h0F;
            2'b11:   strb_base = 8'hFF;
            default: strb_base = 8'hFF;
        endcase
    endfunction

    // Truncate an already right-justified doubleword to the access size and extend.
    function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  load_ext = {{56{raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{48{raw[15]}}, raw[15:0]};
            3'b010:  load_ext = {{32{raw[31]}}, raw[31:0]};
            3'b100:  load_ext = {56'd0, raw[7:0]};
            3'b101:  load_ext = {48'd0, raw[15:0]};
            3'b110:  load_ext = {32'd0, raw[31:0]};
            default: load_ext = raw;
        endcase
    endfunction

    // Decode, alignment check and request field formatting.
    always_comb begin
        is_load_s  = (opcode == LOAD_OP);
        is_store_s = (opcode == STORE_OP);
        mem_op_s   = !noop && (is_load_s || is_store_s);
        mis_s      = mem_op_s && ((ALUresult[2:0] & align_mask(funct3[1:0])) != 3'b000);
        req_we     = is_store_s;
        req_addr   = {ALUresult[XLEN-1:3], 3'b000};
        req_wdata  = valB << {ALUresult[2:0], 3'b000};
        req_strb   = strb_base(funct3[1:0]) << ALUresult[2:0];
    end

    // Handshake-driven stall control.
    always_comb begin
        hit       = 1'b0;
        req_valid = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (mem_op_s && !mis_s) begin
                    req_valid = 1'b1;
                    hit       = 1'b0;
                end else begin
                    req_valid = 1'b0;
                    hit       = 1'b1;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                hit       = 1'b0;
            end
            S_WAIT: begin
                req_valid = 1'b0;
                hit       = resp_valid;
            end
            default: begin
                req_valid = 1'b0;
                hit       = 1'b0;
            end
        endcase
    end

    // Writeback value and register-write enable for the instruction in this stage.
    always_comb begin
        wb_data_s = ALUresult;
        wb_we_s   = 1'b0;
        if (mis_s || noop) begin
            wb_data_s = ALUresult;
            wb_we_s   = 1'b0;
        end else if (is_load_s) begin
            wb_data_s = load_ext(resp_rdata >> {ALUresult[2:0], 3'b000}, funct3);
            wb_we_s   = (rd != 5'd0);
        end else begin
            wb_data_s = ALUresult;
            wb_we_s   = (rd != 5'd0) && !is_store_s && (opcode != BRANCH_OP);
        end
    end

    // Access FSM and MEM/WB register; WB only advances with the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= S_IDLE;
            wb_data       <= '0;
            wb_rd         <= 5'd0;
            wb_we         <= 1'b0;
            wb_noop       <= 1'b1;
            wb_pc         <= '0;
            wb_misaligned <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (mem_op_s && !mis_s) begin
                        state_r <= req_ready ? S_WAIT : S_REQ;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        state_r <= S_WAIT;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
            if (hit) begin
                wb_data       <= wb_data_s;
                wb_rd         <= rd;
                wb_we         <= wb_we_s;
                wb_noop       <= noop;
                wb_pc         <= pc;
                wb_misaligned <= mis_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; the bench plays the data cache by hand.
module tb_mem_stage;

    localparam logic [6:0] LOAD_OP   = 7'b0000011;
    localparam logic [6:0] STORE_OP  = 7'b0100011;
    localparam logic [6:0] ALU_OP    = 7'b0110011;
    localparam logic [6:0] BRANCH_OP = 7'b1100011;

    logic        clk;
    logic        rst_n;
    logic [63:0] ALUresult;
    logic [63:0] valB;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        noop;
    logic [63:0] pc;
    logic        hit;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_strb;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic        wb_noop;
    logic [63:0] wb_pc;
    logic        wb_misaligned;

    int checks;
    int failures;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ALUresult(ALUresult), .valB(valB), .rd(rd),
        .opcode(opcode), .funct3(funct3), .noop(noop), .pc(pc), .hit(hit),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we), .wb_noop(wb_noop), .wb_pc(wb_pc),
        .wb_misaligned(wb_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r, input logic n,
                         input logic [63:0] p);
        opcode = op; funct3 = f3; ALUresult = a; valB = b; rd = r; noop = n; pc = p;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 64'd0;
        drive(ALU_OP, 3'b000, 64'h55, 64'd0, 5'd9, 1'b0, 64'h40);
        tick(); tick();
        checks++; if (wb_noop !== 1'b1) begin failures++; $display("FAIL reset_wb_noop got=%0b exp=1", wb_noop); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we got=%0b exp=0", wb_we); end
        checks++; if (wb_data !== 64'd0 || wb_rd !== 5'd0 || wb_pc !== 64'd0 || wb_misaligned !== 1'b0) begin
            failures++; $display("FAIL reset_wb_fields data=%h rd=%0d pc=%h mis=%0b exp all zero", wb_data, wb_rd, wb_pc, wb_misaligned); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_alu(input logic [6:0] op, input logic [63:0] a, input logic [4:0] r,
                            input logic exp_we, input string name);
        drive(op, 3'b000, a, 64'd0, r, 1'b0, 64'h100);
        checks++; if (hit !== 1'b1 || req_valid !== 1'b0) begin failures++;
            $display("FAIL %s_comb hit=%0b req_valid=%0b exp hit=1 req_valid=0", name, hit, req_valid); end
        tick();
        checks++; if (wb_data !== a || wb_we !== exp_we || wb_rd !== r || wb_pc !== 64'h100 || wb_noop !== 1'b0) begin
            failures++; $display("FAIL %s_wb data=%h we=%0b rd=%0d pc=%h noop=%0b exp data=%h we=%0b rd=%0d pc=100 noop=0",
                                 name, wb_data, wb_we, wb_rd, wb_pc, wb_noop, a, exp_we, r); end
    endtask

    // Load with immediate accept, `wait_cycles` idle cycles in WAIT, then the response.
    task automatic do_load(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] rdata,
                           input int wait_cycles, input logic [63:0] exp_addr,
                           input logic [7:0] exp_strb, input logic [63:0] exp_data, input string name);
        logic [63:0] prev;
        prev = wb_data;
        req_ready = 1'b1;
        drive(LOAD_OP, f3, a, 64'd0, 5'd7, 1'b0, 64'h200);
        checks++; if (req_valid !== 1'b1 || hit !== 1'b0 || req_we !== 1'b0) begin failures++;
            $display("FAIL %s_req valid=%0b hit=%0b we=%0b exp 1 0 0", name, req_valid, hit, req_we); end
        checks++; if (req_addr !== exp_addr || req_strb !== exp_strb) begin failures++;
            $display("FAIL %s_fields addr=%h strb=%h exp addr=%h strb=%h", name, req_addr, req_strb, exp_addr, exp_strb); end
        tick();
        req_ready = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            #1;
            checks++; if (hit !== 1'b0 || req_valid !== 1'b0 || wb_data !== prev) begin failures++;
                $display("FAIL %s_wait%0d hit=%0b req_valid=%0b wb_data=%h exp 0 0 %h", name, i, hit, req_valid, wb_data, prev); end
            tick();
        end
        resp_valid = 1'b1; resp_rdata = rdata;
        #1;
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL %s_resp_hit got=%0b exp=1", name, hit); end
        tick();
        resp_valid = 1'b0; resp_rdata = 64'd0;
        checks++; if (wb_data !== exp_data || wb_we !== 1'b1 || wb_rd !== 5'd7 || wb_misaligned !== 1'b0) begin failures++;
            $display("FAIL %s_wb data=%h we=%0b rd=%0d mis=%0b exp data=%h we=1 rd=7 mis=0", name, wb_data, wb_we, wb_rd, wb_misaligned, exp_data); end
    endtask

    task automatic test_store();
        logic [63:0] prev;
        prev = wb_data;
        req_ready = 1'b0;
        drive(STORE_OP, 3'b010, 64'h2004, 64'hDEADBEEF, 5'd4, 1'b0, 64'h300);
        checks++; if (req_valid !== 1'b1 || hit !== 1'b0 || req_we !== 1'b1) begin failures++;
            $display("FAIL sw_req valid=%0b hit=%0b we=%0b exp 1 0 1", req_valid, hit, req_we); end
        checks++; if (req_strb !== 8'hF0 || req_wdata !== 64'hDEADBEEF_00000000 || req_addr !== 64'h2000) begin failures++;
            $display("FAIL sw_fields strb=%h wdata=%h addr=%h exp f0 deadbeef00000000 2000", req_strb, req_wdata, req_addr); end
        tick();
        #1;
        checks++; if (req_valid !== 1'b1 || hit !== 1'b0 || req_strb !== 8'hF0 || req_wdata !== 64'hDEADBEEF_00000000) begin
            failures++; $display("FAIL sw_held valid=%0b hit=%0b strb=%h wdata=%h", req_valid, hit, req_strb, req_wdata); end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0 || hit !== 1'b0 || wb_data !== prev) begin failures++;
            $display("FAIL sw_wait valid=%0b hit=%0b wb_data=%h exp 0 0 %h", req_valid, hit, wb_data, prev); end
        tick();
        resp_valid = 1'b1;
        #1;
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL sw_ack_hit got=%0b exp=1", hit); end
        tick();
        resp_valid = 1'b0;
        checks++; if (wb_we !== 1'b0 || wb_data !== 64'h2004 || wb_pc !== 64'h300) begin failures++;
            $display("FAIL sw_wb we=%0b data=%h pc=%h exp 0 2004 300", wb_we, wb_data, wb_pc); end
    endtask

    task automatic test_misaligned(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [63:0] a, input string name);
        req_ready = 1'b1;
        drive(op, f3, a, 64'd0, 5'd3, 1'b0, 64'h400);
        checks++; if (req_valid !== 1'b0 || hit !== 1'b1) begin failures++;
            $display("FAIL %s_comb valid=%0b hit=%0b exp 0 1", name, req_valid, hit); end
        tick();
        req_ready = 1'b0;
        checks++; if (wb_misaligned !== 1'b1 || wb_we !== 1'b0 || wb_data !== a) begin failures++;
            $display("FAIL %s_wb mis=%0b we=%0b data=%h exp 1 0 %h", name, wb_misaligned, wb_we, wb_data, a); end
    endtask

    task automatic test_noop();
        req_ready = 1'b1;
        drive(LOAD_OP, 3'b011, 64'h5000, 64'd0, 5'd6, 1'b1, 64'h500);
        checks++; if (req_valid !== 1'b0 || hit !== 1'b1) begin failures++;
            $display("FAIL noop_comb valid=%0b hit=%0b exp 0 1", req_valid, hit); end
        tick();
        req_ready = 1'b0;
        checks++; if (wb_we !== 1'b0 || wb_noop !== 1'b1 || wb_misaligned !== 1'b0) begin failures++;
            $display("FAIL noop_wb we=%0b noop=%0b mis=%0b exp 0 1 0", wb_we, wb_noop, wb_misaligned); end
    endtask

    task automatic test_reset_mid();
        req_ready = 1'b1;
        drive(LOAD_OP, 3'b011, 64'h6000, 64'd0, 5'd8, 1'b0, 64'h600);
        tick();
        req_ready = 1'b0;
        // A response presented in IDLE after reset must be ignored.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (wb_noop !== 1'b1 || wb_we !== 1'b0) begin failures++;
            $display("FAIL rstmid_wb noop=%0b we=%0b exp 1 0", wb_noop, wb_we); end
        drive(ALU_OP, 3'b000, 64'h77, 64'd0, 5'd2, 1'b0, 64'h610);
        resp_valid = 1'b1;
        #1;
        checks++; if (req_valid !== 1'b0 || hit !== 1'b1) begin failures++;
            $display("FAIL rstmid_idle valid=%0b hit=%0b exp 0 1", req_valid, hit); end
        tick();
        resp_valid = 1'b0;
        checks++; if (wb_data !== 64'h77 || wb_we !== 1'b1 || wb_rd !== 5'd2) begin failures++;
            $display("FAIL rstmid_add data=%h we=%0b rd=%0d exp 77 1 2", wb_data, wb_we, wb_rd); end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_alu(ALU_OP, 64'h1234, 5'd5, 1'b1, "add");
        test_alu(ALU_OP, 64'h99, 5'd0, 1'b0, "add_x0");
        test_alu(BRANCH_OP, 64'h1, 5'd3, 1'b0, "branch");
        do_load(3'b000, 64'h1003, 64'h0000_0000_8000_0000, 3, 64'h1000, 8'h08, 64'hFFFF_FFFF_FFFF_FF80, "lb");
        do_load(3'b100, 64'h1003, 64'h0000_0000_8000_0000, 3, 64'h1000, 8'h08, 64'h80, "lbu");
        do_load(3'b010, 64'h1004, 64'h8765_4321_0000_0000, 0, 64'h1000, 8'hF0, 64'hFFFF_FFFF_8765_4321, "lw");
        do_load(3'b101, 64'h1006, 64'h8765_4321_0000_0000, 1, 64'h1000, 8'hC0, 64'h8765, "lhu");
        do_load(3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 2, 64'h1008, 8'hFF, 64'h0123_4567_89AB_CDEF, "ld");
        test_store();
        test_misaligned(LOAD_OP, 3'b011, 64'h3004, "ld_mis");
        test_misaligned(STORE_OP, 3'b001, 64'h3001, "sh_mis");
        test_noop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
